// File: rtl/ysyx_22050499_lsu.sv
// Load/store unit: holds one EXU bundle, runs a single-beat bus access,
// and hands the aligned/extended result to writeback.
module ysyx_22050499_lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         mem_in_valid,
    output logic         mem_in_ready,
    input  logic [148:0] mem_in_bits,
    output logic         mem_out_valid,
    input  logic         mem_out_ready,
    output logic [108:0] mem_out_bits,
    output logic [31:0]  mem_pc,
    output logic [4:0]   mem_Rd,
    output logic         req_valid,
    input  logic         req_ready,
    output logic         req_we,
    output logic [31:0]  req_addr,
    output logic [31:0]  req_wdata,
    output logic [3:0]   req_wstrb,
    input  logic         resp_valid,
    input  logic [31:0]  resp_rdata,
    input  logic         resp_err,
    output logic         lsu_exc
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t       state, state_n;
    logic [148:0] bundle;
    logic [31:0]  rd_q;
    logic         we_q;
    logic         exc_q;
    logic [7:0]   cnt;

    logic        accept, in_mem, in_mis, timeout;
    logic [2:0]  in_w;
    logic [31:0] in_addr;
    logic [2:0]  b_w;
    logic [31:0] b_addr, b_rs2, shifted, load_data;
    logic        b_ld, b_st;
    logic        unused_sext;

    assign in_w    = mem_in_bits[50:48];
    assign in_addr = mem_in_bits[114:83];
    assign in_mem  = mem_in_bits[148] | mem_in_bits[44];
    assign in_mis  = in_mem & ((in_w == 3'b001 & in_addr[0]) |
                     (in_w != 3'b000 & in_w != 3'b001 & |in_addr[1:0]));

    assign b_w    = bundle[50:48];
    assign b_addr = bundle[114:83];
    assign b_rs2  = bundle[82:51];
    assign b_st   = bundle[44];
    assign b_ld   = bundle[148] & ~bundle[44];
    assign unused_sext = ^bundle[47:46];

    assign mem_in_ready = (state == IDLE) | (state == DONE & mem_out_ready);
    assign accept  = mem_in_valid & mem_in_ready;
    assign timeout = (cnt == 8'(TIMEOUT - 1));

    // Lane select by byte offset, then extend per access width
    assign shifted = resp_rdata >> {b_addr[1:0], 3'b000};
    always_comb begin
        load_data = shifted;
        unique case (b_w)
            3'b000:  load_data = {{24{bundle[45] & shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{bundle[45] & shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (accept) state_n = (in_mem & ~in_mis) ? REQ : DONE;
            REQ:  if (req_ready) state_n = RESP;
            RESP: if (resp_valid | timeout) state_n = DONE;
            DONE: if (mem_out_ready)
                      state_n = !accept ? IDLE :
                                (in_mem & ~in_mis) ? REQ : DONE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        req_valid     = 1'b0;
        mem_out_valid = 1'b0;
        unique case (state)
            REQ:     req_valid = 1'b1;
            DONE:    mem_out_valid = 1'b1;
            default: ;
        endcase
    end

    assign req_we    = req_valid & b_st;
    assign req_addr  = req_valid ? b_addr : 32'h0;
    always_comb begin
        req_wdata = 32'h0;
        req_wstrb = 4'h0;
        if (req_valid & b_st) begin
            unique case (b_w)
                3'b000: begin
                    req_wdata = {4{b_rs2[7:0]}};
                    req_wstrb = 4'b0001 << b_addr[1:0];
                end
                3'b001: begin
                    req_wdata = {2{b_rs2[15:0]}};
                    req_wstrb = 4'b0011 << b_addr[1:0];
                end
                default: begin
                    req_wdata = b_rs2;
                    req_wstrb = 4'b1111;
                end
            endcase
        end
    end

    assign mem_pc  = (state != IDLE) ? bundle[147:116] : 32'h0;
    assign mem_Rd  = (state != IDLE & bundle[0]) ? bundle[6:2] : 5'h0;
    assign lsu_exc = exc_q;
    assign mem_out_bits = {bundle[147:115], rd_q, bundle[43:1], we_q};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bundle <= '0;
            rd_q   <= '0;
            we_q   <= 1'b0;
            exc_q  <= 1'b0;
            cnt    <= '0;
        end else begin
            exc_q <= 1'b0;
            if (accept) begin
                bundle <= mem_in_bits;
                rd_q   <= mem_in_bits[114:83];
                we_q   <= mem_in_bits[0] & ~in_mis;
                exc_q  <= in_mis;
            end
            if (state == RESP) begin
                if (!resp_valid && cnt != 8'hFF) cnt <= cnt + 8'd1;
                if ((resp_valid & resp_err) | (~resp_valid & timeout)) begin
                    rd_q  <= '0;
                    we_q  <= 1'b0;
                    exc_q <= 1'b1;
                end else if (resp_valid & b_ld & bundle[11:10] == 2'b01) begin
                    rd_q <= load_data;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22050499_lsu.sv
// Directed bench for the LSU: ALU pass-through, loads, stores,
// misalign, timeout, back-to-back handoff and mid-op reset.
module tb_ysyx_22050499_lsu;

    logic         clock = 1'b0;
    logic         reset;
    logic         mem_in_valid, mem_in_ready;
    logic [148:0] mem_in_bits;
    logic         mem_out_valid, mem_out_ready;
    logic [108:0] mem_out_bits;
    logic [31:0]  mem_pc;
    logic [4:0]   mem_Rd;
    logic         req_valid, req_ready, req_we;
    logic [31:0]  req_addr, req_wdata;
    logic [3:0]   req_wstrb;
    logic         resp_valid, resp_err;
    logic [31:0]  resp_rdata;
    logic         lsu_exc;

    int total = 0;
    int bad   = 0;
    localparam logic [31:0] CSRS = 32'hC0DE0001;

    always #5 clock = ~clock;

    ysyx_22050499_lsu dut (
        .clock(clock), .reset(reset),
        .mem_in_valid(mem_in_valid), .mem_in_ready(mem_in_ready),
        .mem_in_bits(mem_in_bits),
        .mem_out_valid(mem_out_valid), .mem_out_ready(mem_out_ready),
        .mem_out_bits(mem_out_bits),
        .mem_pc(mem_pc), .mem_Rd(mem_Rd),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .lsu_exc(lsu_exc)
    );

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [148:0] mk(
        input logic re, input logic [31:0] pc, input logic [31:0] alu,
        input logic [31:0] rs2, input logic [2:0] w, input logic sx,
        input logic we, input logic [1:0] m2r, input logic [4:0] rd,
        input logic rwe);
        return {re, pc, 1'b0, alu, rs2, w, {2'b00, sx}, we, CSRS,
                m2r, 3'b101, rd, 1'b0, rwe};
    endfunction

    function automatic logic [108:0] mko(
        input logic [31:0] pc, input logic [31:0] rdd,
        input logic [1:0] m2r, input logic [4:0] rd, input logic rwe);
        return {pc, 1'b0, rdd, CSRS, m2r, 3'b101, rd, 1'b0, rwe};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [148:0] b);
        mem_in_valid = 1'b1;
        mem_in_bits  = b;
        tick();
        mem_in_valid = 1'b0;
    endtask

    task automatic drain();
        mem_out_ready = 1'b1;
        tick();
        mem_out_ready = 1'b0;
        chk("drain_idle", mem_out_valid, 1'b0);
    endtask

    task automatic ld(input string tag, input logic [148:0] b,
                      input logic [31:0] rdata, input logic err,
                      input logic [108:0] exp_out, input logic exp_exc);
        issue(b);
        chk({tag, "_req"}, req_valid, 1'b1);
        chk({tag, "_strb"}, req_wstrb, 4'h0);
        req_ready = 1'b1;
        tick();
        req_ready  = 1'b0;
        resp_valid = 1'b1;
        resp_rdata = rdata;
        resp_err   = err;
        tick();
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        chk({tag, "_ov"}, mem_out_valid, 1'b1);
        chk({tag, "_bits"}, mem_out_bits, exp_out);
        chk({tag, "_exc"}, lsu_exc, exp_exc);
        drain();
    endtask

    initial begin
        reset = 1'b0;
        mem_in_valid = 1'b0; mem_in_bits = '0; mem_out_ready = 1'b0;
        req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = '0;
        resp_err = 1'b0;
        repeat (3) tick();
        chk("rst_ov", mem_out_valid, 1'b0);
        chk("rst_req", req_valid, 1'b0);
        chk("rst_bits", mem_out_bits, '0);
        chk("rst_pc", mem_pc, 32'h0);
        chk("rst_exc", lsu_exc, 1'b0);
        reset = 1'b1;
        tick();

        // ALU op: one-cycle latency, no bus traffic
        mem_in_valid = 1'b1;
        mem_in_bits  = mk(0, 32'h80000000, 32'h1234, 0, 3'b010, 0, 0,
                          2'b00, 5'd5, 1);
        #1 chk("alu_inrdy", mem_in_ready, 1'b1);
        tick();
        mem_in_valid = 1'b0;
        chk("alu_ov", mem_out_valid, 1'b1);
        chk("alu_req", req_valid, 1'b0);
        chk("alu_bits", mem_out_bits,
            mko(32'h80000000, 32'h1234, 2'b00, 5'd5, 1));
        chk("alu_pc", mem_pc, 32'h80000000);
        chk("alu_rd", mem_Rd, 5'd5);
        drain();
        chk("idle_pc", mem_pc, 32'h0);

        // Loads: lane select and extension
        ld("lb", mk(1, 32'h100, 32'h103, 0, 3'b000, 1, 0, 2'b01, 5'd7, 1),
           32'h80FFFFFF, 0, mko(32'h100, 32'hFFFFFF80, 2'b01, 5'd7, 1), 0);
        ld("lbu", mk(1, 32'h104, 32'h103, 0, 3'b000, 0, 0, 2'b01, 5'd7, 1),
           32'h80FFFFFF, 0, mko(32'h104, 32'h00000080, 2'b01, 5'd7, 1), 0);
        ld("lh", mk(1, 32'h108, 32'h102, 0, 3'b001, 1, 0, 2'b01, 5'd8, 1),
           32'h87654321, 0, mko(32'h108, 32'hFFFF8765, 2'b01, 5'd8, 1), 0);
        ld("lhu", mk(1, 32'h10C, 32'h102, 0, 3'b001, 0, 0, 2'b01, 5'd8, 1),
           32'h87654321, 0, mko(32'h10C, 32'h00008765, 2'b01, 5'd8, 1), 0);
        ld("lw", mk(1, 32'h110, 32'h104, 0, 3'b010, 1, 0, 2'b01, 5'd9, 1),
           32'hDEADBEEF, 0, mko(32'h110, 32'hDEADBEEF, 2'b01, 5'd9, 1), 0);
        ld("lw_m2r0", mk(1, 32'h114, 32'h104, 0, 3'b010, 0, 0, 2'b00, 5'd9, 1),
           32'hDEADBEEF, 0, mko(32'h114, 32'h104, 2'b00, 5'd9, 1), 0);
        ld("lw_err", mk(1, 32'h118, 32'h104, 0, 3'b010, 0, 0, 2'b01, 5'd9, 1),
           32'hDEADBEEF, 1, mko(32'h118, 32'h0, 2'b01, 5'd9, 0), 1);

        // sh with a stalled bus: fields must hold
        issue(mk(0, 32'h200, 32'h102, 32'hABCD1234, 3'b001, 0, 1,
                 2'b00, 5'd0, 0));
        for (int i = 0; i < 3; i++) begin
            chk("sh_req", req_valid, 1'b1);
            chk("sh_we", req_we, 1'b1);
            chk("sh_addr", req_addr, 32'h102);
            chk("sh_strb", req_wstrb, 4'b1100);
            chk("sh_wdata", req_wdata, 32'h12341234);
            tick();
        end
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        chk("sh_resp_req", req_valid, 1'b0);
        resp_valid = 1'b1;
        tick();
        resp_valid = 1'b0;
        chk("sh_bits", mem_out_bits, mko(32'h200, 32'h102, 2'b00, 5'd0, 0));
        drain();

        // sb lane replication
        issue(mk(0, 32'h204, 32'h301, 32'h000000A5, 3'b000, 0, 1,
                 2'b00, 5'd0, 0));
        chk("sb_strb", req_wstrb, 4'b0010);
        chk("sb_wdata", req_wdata, 32'hA5A5A5A5);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        resp_valid = 1'b1;
        tick();
        resp_valid = 1'b0;
        drain();

        // Misaligned lw: no request, exception pulse, RegWe dropped
        issue(mk(1, 32'h300, 32'h101, 0, 3'b010, 0, 0, 2'b01, 5'd3, 1));
        chk("mis_req", req_valid, 1'b0);
        chk("mis_ov", mem_out_valid, 1'b1);
        chk("mis_exc", lsu_exc, 1'b1);
        chk("mis_bits", mem_out_bits, mko(32'h300, 32'h101, 2'b01, 5'd3, 0));
        tick();
        chk("mis_exc_pulse", lsu_exc, 1'b0);
        chk("mis_hold", mem_out_valid, 1'b1);
        drain();

        // Timeout: no response ever arrives
        issue(mk(1, 32'h400, 32'h200, 0, 3'b010, 0, 0, 2'b01, 5'd4, 1));
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        repeat (254) tick();
        chk("to_early", mem_out_valid, 1'b0);
        tick();
        chk("to_ov", mem_out_valid, 1'b1);
        chk("to_exc", lsu_exc, 1'b1);
        chk("to_bits", mem_out_bits, mko(32'h400, 32'h0, 2'b01, 5'd4, 0));
        drain();

        // Back-pressure then back-to-back accept
        issue(mk(0, 32'h500, 32'h77, 0, 3'b010, 0, 0, 2'b00, 5'd6, 1));
        repeat (5) begin
            chk("bp_ov", mem_out_valid, 1'b1);
            chk("bp_inrdy", mem_in_ready, 1'b0);
            tick();
        end
        chk("bp_bits", mem_out_bits, mko(32'h500, 32'h77, 2'b00, 5'd6, 1));
        mem_in_valid = 1'b1;
        mem_in_bits  = mk(0, 32'h504, 32'h55, 0, 3'b010, 0, 0,
                          2'b00, 5'd9, 1);
        mem_out_ready = 1'b1;
        #1 chk("b2b_inrdy", mem_in_ready, 1'b1);
        tick();
        mem_in_valid = 1'b0;
        chk("b2b_ov", mem_out_valid, 1'b1);
        chk("b2b_bits", mem_out_bits, mko(32'h504, 32'h55, 2'b00, 5'd9, 1));
        tick();
        mem_out_ready = 1'b0;
        chk("b2b_idle", mem_out_valid, 1'b0);

        // Reset during RESP, then a stale response
        issue(mk(1, 32'h600, 32'h300, 0, 3'b010, 0, 0, 2'b01, 5'd2, 1));
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        reset = 1'b0;
        #1;
        chk("mr_req", req_valid, 1'b0);
        chk("mr_ov", mem_out_valid, 1'b0);
        chk("mr_pc", mem_pc, 32'h0);
        chk("mr_bits", mem_out_bits, '0);
        tick();
        reset = 1'b1;
        resp_valid = 1'b1;
        resp_rdata = 32'h12345678;
        tick();
        resp_valid = 1'b0;
        chk("mr_stale_ov", mem_out_valid, 1'b0);
        chk("mr_stale_exc", lsu_exc, 1'b0);
        chk("mr_inrdy", mem_in_ready, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
